// File: rtl/l1_i_data_array_nway_if.sv
// Bundle between the L1_I controller / L2 read-data bus and the
// N-way instruction-cache data array.
// The master side is the controller: it issues fetch reads and refill beats.
// The slave side is the data array itself.
interface l1_i_data_array_nway_if #(
  parameter int WAYS      = 2,
  parameter int INUM      = 5,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32,
  parameter int BEAT_BITS = 128
);
  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam int WW  = $clog2(WAYS);

  logic                 rd_req;
  logic                 rd_ready;
  logic [INUM-1:0]      index_C_L1;
  logic [OFF-1:0]       offset;
  logic [WW-1:0]        way;
  logic [WORD_BITS-1:0] read_data_L1_C;
  logic                 rd_valid;
  logic                 rd_crit;
  logic                 refill_start;
  logic                 beat_valid;
  logic [BEAT_BITS-1:0] read_data_L2_L1;
  logic                 busy;
  logic                 refill_done;

  modport master (
    output rd_req, index_C_L1, offset, way, refill_start, beat_valid, read_data_L2_L1,
    input  rd_ready, read_data_L1_C, rd_valid, rd_crit, busy, refill_done
  );

  modport slave (
    input  rd_req, index_C_L1, offset, way, refill_start, beat_valid, read_data_L2_L1,
    output rd_ready, read_data_L1_C, rd_valid, rd_crit, busy, refill_done
  );
endinterface

// File: rtl/l1_i_data_array_nway.sv
// N-way L1 instruction-cache data array.
// Serves single-word fetch reads with one cycle of latency. It accepts
// line refills as BEATS beats that arrive critical-beat-first and wrap
// around. The critical word is forwarded to the core in the cycle after
// the first beat, so the core does not wait for the rest of the line.
module l1_i_data_array_nway #(
  parameter int WAYS      = 2,
  parameter int INUM      = 5,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32,
  parameter int BEAT_BITS = 128
) (
  input logic                    clk,
  input logic                    rst,
  l1_i_data_array_nway_if.slave  bus
);
  localparam int SETS  = 2 ** INUM;
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int WOFF  = $clog2(WORD_BITS / 8);
  localparam int BOFF  = $clog2(BEAT_BITS / 8);
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int WPB   = BEAT_BITS / WORD_BITS;
  localparam int WW    = $clog2(WAYS);
  // Keep the pointer and word-select fields at least 1 bit wide. This lets
  // the BEATS==1 and WPB==1 builds still declare them.
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WW-1:0]        fill_way;
  logic [INUM-1:0]      fill_index;
  logic [BW-1:0]        bptr;
  logic [BW-1:0]        cnt;
  logic [CW-1:0]        cwidx;
  logic                 busy_q;
  logic                 refill_done_q;
  logic                 rd_valid_q;
  logic                 rd_crit_q;
  logic [WORD_BITS-1:0] read_data_q;

  // Line storage, split into beat-sized slots. It is not reset.
  logic [BEAT_BITS-1:0] mem [WAYS][SETS][BEATS];

  logic [BW-1:0]        off_slot;
  logic [CW-1:0]        off_word;
  logic [BW-1:0]        bptr_next;
  logic [BEAT_BITS-1:0] rd_beat;
  logic [WORD_BITS-1:0] rd_word_data;
  logic [WORD_BITS-1:0] crit_word;
  logic                 rd_ready_int;
  logic                 beat_take;

  // Decode the offset into a beat slot and a word inside that beat; form read/forward words.
  always_comb begin
    off_slot     = '0;
    off_word     = '0;
    bptr_next    = '0;
    if (BEATS > 1) begin
      off_slot  = BW'(bus.offset >> BOFF);
      bptr_next = bptr + BW'(1);
    end else begin
      off_slot  = '0;
      bptr_next = '0;
    end
    if (WPB > 1) begin
      off_word = CW'(bus.offset >> WOFF);
    end else begin
      off_word = '0;
    end
    rd_beat      = mem[bus.way][bus.index_C_L1][off_slot];
    rd_word_data = rd_beat[off_word*WORD_BITS +: WORD_BITS];
    crit_word    = bus.read_data_L2_L1[cwidx*WORD_BITS +: WORD_BITS];
  end

  // A refill start steals the read port in the cycle it is presented.
  assign rd_ready_int = (state == IDLE) && !bus.refill_start;
  assign beat_take    = (state == FILL) && bus.beat_valid;

  // Refill FSM plus the registered read / critical-word output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fill_way      <= '0;
      fill_index    <= '0;
      bptr          <= '0;
      cnt           <= '0;
      cwidx         <= '0;
      busy_q        <= 1'b0;
      refill_done_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_crit_q     <= 1'b0;
      read_data_q   <= '0;
    end else begin
      rd_valid_q    <= 1'b0;
      rd_crit_q     <= 1'b0;
      refill_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.refill_start) begin
            state      <= FILL;
            fill_way   <= bus.way;
            fill_index <= bus.index_C_L1;
            bptr       <= off_slot;
            cwidx      <= off_word;
            cnt        <= '0;
            busy_q     <= 1'b1;
          end else if (bus.rd_req) begin
            rd_valid_q  <= 1'b1;
            read_data_q <= rd_word_data;
          end else begin
            state <= IDLE;
          end
        end
        FILL: begin
          if (bus.beat_valid) begin
            bptr <= bptr_next;
            cnt  <= cnt + BW'(1);
            // The first beat carries the critical word. Forward it from the bus.
            if (cnt == '0) begin
              rd_valid_q  <= 1'b1;
              rd_crit_q   <= 1'b1;
              read_data_q <= crit_word;
            end else begin
              rd_crit_q <= 1'b0;
            end
            if (cnt == LAST_BEAT) begin
              state         <= DONE;
              busy_q        <= 1'b0;
              refill_done_q <= 1'b1;
            end else begin
              state <= FILL;
            end
          end else begin
            state <= FILL;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Beat write into the latched way/set. Only the slot the pointer selects changes.
  always_ff @(posedge clk) begin
    if (beat_take) begin
      mem[fill_way][fill_index][bptr] <= bus.read_data_L2_L1;
    end
  end

  assign bus.rd_ready       = rd_ready_int;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_crit        = rd_crit_q;
  assign bus.read_data_L1_C = read_data_q;
  assign bus.busy           = busy_q;
  assign bus.refill_done    = refill_done_q;
endmodule

// File: tb/tb_l1_i_data_array_nway.sv
// Directed bench for l1_i_data_array_nway.
// It instantiates a 2-way/4-beat build (a) and a 4-way/1-beat build (b).
// Expected read words are pushed to per-DUT queues when a read or a first
// beat is driven. They are popped when rd_valid is seen.
module tb_l1_i_data_array_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_i_data_array_nway_if #(.WAYS(2), .INUM(5), .LINE_BITS(512), .WORD_BITS(32), .BEAT_BITS(128)) a ();
  l1_i_data_array_nway_if #(.WAYS(4), .INUM(5), .LINE_BITS(512), .WORD_BITS(32), .BEAT_BITS(512)) b ();

  l1_i_data_array_nway #(.WAYS(2), .INUM(5), .LINE_BITS(512), .WORD_BITS(32), .BEAT_BITS(128)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  l1_i_data_array_nway #(.WAYS(4), .INUM(5), .LINE_BITS(512), .WORD_BITS(32), .BEAT_BITS(512)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        crit;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  logic [511:0] model_a [2][32];
  logic [511:0] model_b [4][32];
  int passed = 0;
  int total  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input logic [15:0] seed);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) begin
      l[k*32 +: 32] = {seed, 12'hA50, 4'(k)};
    end
    return l;
  endfunction

  // Scoreboard for build a.
  always @(negedge clk) begin
    if (a.rd_valid === 1'b1) begin
      chk1("a_sb_has_entry", qa.size() != 0, 1'b1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk32("a_rd_data", a.read_data_L1_C, ea.data);
        chk1("a_rd_crit", a.rd_crit, ea.crit);
      end
    end
  end

  // Scoreboard for build b.
  always @(negedge clk) begin
    if (b.rd_valid === 1'b1) begin
      chk1("b_sb_has_entry", qb.size() != 0, 1'b1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk32("b_rd_data", b.read_data_L1_C, eb.data);
        chk1("b_rd_crit", b.rd_crit, eb.crit);
      end
    end
  end

  // Full 4-beat refill on build a.
  // mode 0: no bubble. mode 1: 1-cycle bubble after the first beat.
  // mode 2: the bubble also carries a stray refill_start aimed at another way/set.
  task automatic fill_a(input logic w, input logic [4:0] idx, input logic [5:0] off,
                        input logic [511:0] line, input int mode);
    int crit;
    int slot;
    crit = int'(off) >> 4;
    a.refill_start = 1'b1;
    a.way = w;
    a.index_C_L1 = idx;
    a.offset = off;
    #1;
    chk1("a_rd_ready_at_start", a.rd_ready, 1'b0);
    tick();
    a.refill_start = 1'b0;
    chk1("a_busy_after_start", a.busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      slot = (crit + i) % 4;
      a.beat_valid = 1'b1;
      a.read_data_L2_L1 = line[slot*128 +: 128];
      if (i == 0) begin
        qa.push_back('{data: line[(int'(off) >> 2)*32 +: 32], crit: 1'b1});
      end
      tick();
      a.beat_valid = 1'b0;
      a.read_data_L2_L1 = {4{32'hDEAD_BEEF}};
      if (i == 0) begin
        chk1("a_crit_valid", a.rd_valid, 1'b1);
      end
      if (i < 3) begin
        chk1("a_busy_fill", a.busy, 1'b1);
        chk1("a_done_early", a.refill_done, 1'b0);
        chk1("a_rd_ready_fill", a.rd_ready, 1'b0);
      end else begin
        chk1("a_busy_done", a.busy, 1'b0);
        chk1("a_refill_done", a.refill_done, 1'b1);
      end
      if (i == 0 && mode > 0) begin
        if (mode == 2) begin
          a.refill_start = 1'b1;
          a.index_C_L1 = idx ^ 5'd1;
          a.way = ~w;
        end
        tick();
        a.refill_start = 1'b0;
        a.index_C_L1 = idx;
        a.way = w;
        chk1("a_busy_bubble", a.busy, 1'b1);
        chk1("a_no_valid_bubble", a.rd_valid, 1'b0);
      end
    end
    tick();
    chk1("a_done_pulse_end", a.refill_done, 1'b0);
    chk1("a_busy_idle", a.busy, 1'b0);
    model_a[w][idx] = line;
  endtask

  task automatic read_a(input logic w, input logic [4:0] idx, input logic [5:0] off);
    a.rd_req = 1'b1;
    a.way = w;
    a.index_C_L1 = idx;
    a.offset = off;
    qa.push_back('{data: model_a[w][idx][(int'(off) >> 2)*32 +: 32], crit: 1'b0});
    tick();
    chk1("a_rd_valid", a.rd_valid, 1'b1);
  endtask

  // Single-beat refill on build b: the critical forward and done land in the same cycle.
  task automatic fill_b(input logic [1:0] w, input logic [4:0] idx, input logic [5:0] off,
                        input logic [511:0] line);
    b.refill_start = 1'b1;
    b.way = w;
    b.index_C_L1 = idx;
    b.offset = off;
    tick();
    b.refill_start = 1'b0;
    chk1("b_busy_after_start", b.busy, 1'b1);
    b.beat_valid = 1'b1;
    b.read_data_L2_L1 = line;
    qb.push_back('{data: line[(int'(off) >> 2)*32 +: 32], crit: 1'b1});
    tick();
    b.beat_valid = 1'b0;
    b.read_data_L2_L1 = '0;
    chk1("b_crit_valid", b.rd_valid, 1'b1);
    chk1("b_crit_flag", b.rd_crit, 1'b1);
    chk1("b_refill_done_same", b.refill_done, 1'b1);
    chk1("b_busy_done", b.busy, 1'b0);
    tick();
    chk1("b_done_pulse_end", b.refill_done, 1'b0);
    model_b[w][idx] = line;
  endtask

  task automatic read_b(input logic [1:0] w, input logic [4:0] idx, input logic [5:0] off);
    b.rd_req = 1'b1;
    b.way = w;
    b.index_C_L1 = idx;
    b.offset = off;
    qb.push_back('{data: model_b[w][idx][(int'(off) >> 2)*32 +: 32], crit: 1'b0});
    tick();
    chk1("b_rd_valid", b.rd_valid, 1'b1);
  endtask

  initial begin
    a.rd_req = 1'b0; a.index_C_L1 = '0; a.offset = '0; a.way = '0;
    a.refill_start = 1'b0; a.beat_valid = 1'b0; a.read_data_L2_L1 = '0;
    b.rd_req = 1'b0; b.index_C_L1 = '0; b.offset = '0; b.way = '0;
    b.refill_start = 1'b0; b.beat_valid = 1'b0; b.read_data_L2_L1 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", a.busy, 1'b0);
    chk1("rst_rd_valid", a.rd_valid, 1'b0);
    chk1("rst_rd_crit", a.rd_crit, 1'b0);
    chk1("rst_refill_done", a.refill_done, 1'b0);
    chk32("rst_read_data", a.read_data_L1_C, 32'd0);
    chk1("rst_rd_ready", a.rd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Test 1: reset in the middle of a fill, then a clean fill.
    a.refill_start = 1'b1; a.way = 1'b0; a.index_C_L1 = 5'd3; a.offset = 6'h00;
    tick();
    a.refill_start = 1'b0;
    a.beat_valid = 1'b1;
    a.read_data_L2_L1 = mk_line(16'h1111)[127:0];
    qa.push_back('{data: mk_line(16'h1111)[31:0], crit: 1'b1});
    tick();
    a.beat_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk1("t1_busy_rst_async", a.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t1_busy_rst", a.busy, 1'b0);
      chk1("t1_rd_valid_rst", a.rd_valid, 1'b0);
      chk1("t1_refill_done_rst", a.refill_done, 1'b0);
    end
    rst = 1'b0;
    tick();
    fill_a(1'b0, 5'd3, 6'h08, mk_line(16'h2222), 0);
    read_a(1'b0, 5'd3, 6'h08);
    read_a(1'b0, 5'd3, 6'h30);
    a.rd_req = 1'b0;
    tick();

    // Test 2: way1 idx5, offset 0x24, with a bubble after the critical beat.
    fill_a(1'b1, 5'd5, 6'h24, mk_line(16'h3333), 1);

    // Test 3: read the whole line back-to-back.
    for (int o = 0; o < 64; o += 4) begin
      read_a(1'b1, 5'd5, 6'(o));
    end
    a.rd_req = 1'b0;
    tick();

    // Test 4: no aliasing between ways of one set; the neighbouring set is untouched.
    fill_a(1'b0, 5'd6, 6'h00, mk_line(16'h4444), 0);
    fill_a(1'b0, 5'd7, 6'h00, mk_line(16'h5555), 0);
    fill_a(1'b1, 5'd7, 6'h30, mk_line(16'h6666), 0);
    read_a(1'b0, 5'd7, 6'h00);
    read_a(1'b1, 5'd7, 6'h00);
    read_a(1'b0, 5'd6, 6'h00);
    read_a(1'b0, 5'd6, 6'h3C);
    read_a(1'b1, 5'd5, 6'h24);
    a.rd_req = 1'b0;
    tick();

    // Test 5: beat_valid in IDLE is ignored; reads during a fill and at the start cycle are dropped.
    a.beat_valid = 1'b1; a.way = 1'b1; a.index_C_L1 = 5'd5;
    a.read_data_L2_L1 = {4{32'hBAD0_BAD0}};
    tick();
    a.beat_valid = 1'b0;
    chk1("t5_idle_beat_busy", a.busy, 1'b0);
    chk1("t5_idle_beat_valid", a.rd_valid, 1'b0);
    a.rd_req = 1'b1;
    fill_a(1'b0, 5'd9, 6'h14, mk_line(16'h7777), 2);
    a.rd_req = 1'b0;
    tick();
    read_a(1'b0, 5'd9, 6'h14);
    read_a(1'b0, 5'd9, 6'h00);
    read_a(1'b1, 5'd5, 6'h00);
    read_a(1'b1, 5'd5, 6'h10);
    a.rd_req = 1'b0;
    tick();

    // Test 6: 4-way, single-beat build.
    fill_b(2'd3, 5'd2, 6'h18, mk_line(16'h8888));
    fill_b(2'd0, 5'd2, 6'h00, mk_line(16'h9999));
    read_b(2'd3, 5'd2, 6'h00);
    read_b(2'd3, 5'd2, 6'h18);
    read_b(2'd3, 5'd2, 6'h3C);
    read_b(2'd0, 5'd2, 6'h04);
    b.rd_req = 1'b0;
    tick();
    tick();

    chk32("a_sb_drained", 32'(qa.size()), 32'd0);
    chk32("b_sb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
